avalon_s_wide_buffer: RTL
=========================

# avalon_s_wide_buffer

Parametrised Avalon-MM slave that bridges a narrow host bus to a wide datapath word, generalising the fixed 32/128/1024-bit and 128-byte data types used by the curl unit's Avalon slave. The host writes a wide operand word by word into a fill buffer and commits it to a wide valid/ready output. The host reads a wide result, captured from a valid/ready input, back word by word. The block sits between the HPS/Avalon interconnect and the curl calculation core. It is double-buffered, so the host can fill the next operand while the previous one is still pending.

## Interface
Parameters:
- DATA_W, 32, Avalon data width; multiple of 8.
- WIDE_W, 1024, wide word width; multiple of DATA_W. WORDS = WIDE_W/DATA_W (derived).
- ADDR_W, 6, word address width; 2^ADDR_W >= WORDS+2.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high.
- avs_address  in  ADDR_W  word address.
- avs_write  in  1  write strobe.
- avs_writedata  in  DATA_W  write data.
- avs_byteenable  in  DATA_W/8  byte lanes.
- avs_read  in  1  read strobe.
- avs_readdata  out  DATA_W  read data.
- avs_readdatavalid  out  1  read data valid.
- avs_waitrequest  out  1  stall.
- out_data  out  WIDE_W  committed operand.
- out_valid  out  1  operand pending.
- out_ready  in  1  core accepts operand.
- in_data  in  WIDE_W  result from core.
- in_valid  in  1  result valid.
- in_ready  out  1  result slot free.

## Operation
- Address map:
  - 0..WORDS-1: DATA window. Writes go to the fill buffer; reads return the result buffer.
  - WORDS: CTRL, write-only; reads return 0.
  - WORDS+1: STATUS, read-only; writes are ignored.
  - Any other address: reads return 0, writes are ignored.
- Word i maps to bits [i*DATA_W +: DATA_W] of both the fill buffer and the result buffer. byteenable bit b gates byte b; unenabled bytes keep their old value.
- CTRL write bits:
  - bit0 COMMIT: copy the fill buffer to out_data and set out_valid.
  - bit1 CLEAR: zero the fill buffer; applied after the copy when set together with COMMIT.
  - bit2 RELEASE: clear res_valid.
  - Other bits are ignored. byteenable[0] must be 1 for CTRL to take effect.
- COMMIT while the output slot is occupied (out_valid=1 and not out_valid&&out_ready this cycle):
  - avs_waitrequest=1 until the slot frees.
  - The write is then accepted in the freeing cycle, i.e. the cycle in which out_valid&&out_ready.
- avs_waitrequest is asserted only in the blocked-COMMIT case; it is 0 for all other accesses.
- Result capture:
  - in_ready = !res_valid, forced 0 during reset.
  - On in_valid&&in_ready, in_data is latched into the result buffer and res_valid is set.
  - The result buffer is held until RELEASE.
- STATUS read:
  - bit0 = out_valid.
  - bit1 = res_valid.
  - bits[31:16] = commit counter: 16-bit, increments per accepted COMMIT, wraps 0xFFFF→0. Only bits that fit DATA_W are present.
  - All other bits are 0.
- Read and write in the same cycle: both are serviced; the read returns the pre-write value.
- RELEASE and in_valid in the same cycle: the release takes effect and the new result is not captured. in_ready was 0 that cycle.

## Timing
- Reset values: avs_readdata=0, avs_readdatavalid=0, avs_waitrequest=0, out_data=0, out_valid=0, in_ready=0 (1 in the first cycle after reset deasserts). Fill buffer, result buffer, res_valid and commit counter are all 0.
- Read accepted at cycle T → avs_readdatavalid=1 and avs_readdata valid at T+1, for exactly one cycle. Back-to-back reads are supported at full rate.
- Data write at T → visible in the fill buffer at T+1.
- COMMIT accepted at T → out_valid=1 and out_data updated at T+1.
- out_valid&&out_ready at T with no COMMIT → out_valid=0 at T+1.
- Capture at T → res_valid=1 and in_ready=0 at T+1.
- RELEASE at T → in_ready=1 at T+1.
- Reset mid-operation (including during a stalled COMMIT) clears all state at the next edge. A pending stalled COMMIT is dropped and waitrequest=0 the cycle after.

## Test plan
- Reset, then read STATUS: readdatavalid at T+1 with 0x00000000; in_ready=1.
- Write words 0..31 with value i*0x01010101, then CTRL=0x1 with out_ready=0: out_valid=1 at T+1, out_data word 5 = 0x05050505. STATUS reads 0x00010001.
- While out_valid=1 and out_ready=0, write CTRL=0x3: waitrequest held high. Raise out_ready for one cycle: the COMMIT is accepted in that cycle and out_valid stays 1 with the new data. The fill buffer then reads back as zero once committed again.
- Byteenable: word 3 = 0xAABBCCDD, then write 0x11223344 with byteenable=0b0101; commit → word 3 = 0xAA22CC44.
- Result: drive in_valid with in_data word 7 = 0xDEADBEEF. in_ready falls at T+1, and a second in_valid is ignored. Read address 7 → 0xDEADBEEF. CTRL=0x4 → in_ready=1.
- Perform 65537 commits with out_ready=1: STATUS[31:16] = 0x0001 (wrap).

Source files
------------

// File: rtl/avalon_s_wide_buffer.sv
// Avalon-MM slave that assembles a wide operand from narrow host writes and returns a wide
// result word by word. Double-buffered: a fill buffer feeds a committed valid/ready output.
module avalon_s_wide_buffer #(
  parameter int DATA_W = 32,
  parameter int WIDE_W = 1024,
  parameter int ADDR_W = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   avs_address,
  input  logic                avs_write,
  input  logic [DATA_W-1:0]   avs_writedata,
  input  logic [DATA_W/8-1:0] avs_byteenable,
  input  logic                avs_read,
  output logic [DATA_W-1:0]   avs_readdata,
  output logic                avs_readdatavalid,
  output logic                avs_waitrequest,
  output logic [WIDE_W-1:0]   out_data,
  output logic                out_valid,
  input  logic                out_ready,
  input  logic [WIDE_W-1:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready
);

  localparam int WORDS = WIDE_W / DATA_W;
  localparam int BYTES = DATA_W / 8;
  localparam logic [ADDR_W-1:0] CTRL_ADDR   = ADDR_W'(WORDS);
  localparam logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(WORDS + 1);

  logic [WIDE_W-1:0] fill_buf;
  logic [WIDE_W-1:0] res_buf;
  logic              res_valid;
  logic [15:0]       commit_cnt;

  logic              data_wr;
  logic              ctrl_wr;
  logic              commit_req;
  logic              commit_ok;
  logic              clear_ok;
  logic              release_ok;
  logic              capture;
  logic              rd_ok;
  logic [DATA_W-1:0] status_word;
  logic [DATA_W-1:0] rd_word;

  always_comb begin
    data_wr    = avs_write && (avs_address < CTRL_ADDR);
    ctrl_wr    = avs_write && (avs_address == CTRL_ADDR) && avs_byteenable[0];
    commit_req = ctrl_wr && avs_writedata[0];
    // Stall only when the output slot stays occupied this cycle; a freeing cycle accepts the commit.
    avs_waitrequest = !reset && commit_req && out_valid && !out_ready;
    commit_ok  = commit_req && !avs_waitrequest;
    clear_ok   = ctrl_wr && avs_writedata[1] && !avs_waitrequest;
    release_ok = ctrl_wr && avs_writedata[2] && !avs_waitrequest;
    in_ready   = !reset && !res_valid;
    capture    = in_valid && in_ready;
    rd_ok      = avs_read && !avs_waitrequest;
  end

  always_comb begin
    status_word    = '0;
    status_word[0] = out_valid;
    status_word[1] = res_valid;
    for (int b = 16; b < 32 && b < DATA_W; b++) status_word[b] = commit_cnt[b-16];

    rd_word = '0;
    if (avs_address == STATUS_ADDR) rd_word = status_word;
    for (int w = 0; w < WORDS; w++)
      if (avs_address == ADDR_W'(w)) rd_word = res_buf[w*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      avs_readdata      <= '0;
      avs_readdatavalid <= 1'b0;
      out_data          <= '0;
      out_valid         <= 1'b0;
      fill_buf          <= '0;
      res_buf           <= '0;
      res_valid         <= 1'b0;
      commit_cnt        <= '0;
    end else begin
      avs_readdatavalid <= rd_ok;
      avs_readdata      <= rd_ok ? rd_word : '0;

      if (commit_ok) begin
        out_data   <= fill_buf;
        out_valid  <= 1'b1;
        commit_cnt <= commit_cnt + 16'd1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      // CLEAR lands after the copy above because out_data samples the old fill_buf.
      if (clear_ok) begin
        fill_buf <= '0;
      end else if (data_wr) begin
        for (int w = 0; w < WORDS; w++)
          for (int b = 0; b < BYTES; b++)
            if (avs_address == ADDR_W'(w) && avs_byteenable[b])
              fill_buf[w*DATA_W + b*8 +: 8] <= avs_writedata[b*8 +: 8];
      end

      if (capture) begin
        res_buf   <= in_data;
        res_valid <= 1'b1;
      end else if (release_ok) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule
